// File: rtl/line_clear_engine.sv
// Tetris line-clear engine: snapshots the board, flags full rows, then compacts
// the board in place one row per cycle and keeps a saturating cleared-line total.
module line_clear_engine #(
    parameter int WIDTH   = 10,
    parameter int HEIGHT  = 20,
    parameter int TOTAL_W = 16,
    localparam int CNT_W  = $clog2(HEIGHT + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [0:WIDTH*HEIGHT-1]   board_in,
    input  logic                      clr_total,
    output logic                      busy,
    output logic                      done,
    output logic [0:WIDTH*HEIGHT-1]   board_out,
    output logic [HEIGHT-1:0]         full_lines,
    output logic                      full_line,
    output logic [CNT_W-1:0]          lines_cleared,
    output logic [TOTAL_W-1:0]        lines_total
);

    localparam int IDX_W = $clog2(HEIGHT);
    localparam int SUM_W = ((TOTAL_W > CNT_W) ? TOTAL_W : CNT_W) + 1;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, SCAN, COMPACT, FILL, DONE} state_t;

    state_t              state, state_next;
    logic [WIDTH-1:0]    rows [HEIGHT];
    logic [HEIGHT-1:0]   row_full;
    logic [IDX_W-1:0]    src, dst;

    function automatic logic [CNT_W-1:0] popcount(input logic [HEIGHT-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < HEIGHT; i++) c = c + CNT_W'(m[i]);
        return c;
    endfunction

    function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                   input logic [CNT_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({TOTAL_W{1'b1}})) return {TOTAL_W{1'b1}};
        return s[TOTAL_W-1:0];
    endfunction

    always_comb begin
        row_full = '0;
        for (int r = 0; r < HEIGHT; r++) row_full[r] = &rows[r];
    end

    for (genvar r = 0; r < HEIGHT; r++) begin : g_out
        assign board_out[r*WIDTH +: WIDTH] = rows[r];
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign full_line = |full_lines;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    state_next = (row_full == '0) ? DONE : COMPACT;
            COMPACT: if (src == '0) state_next = FILL;
            FILL:    if (dst == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The mask registered in SCAN steers COMPACT; dst >= src keeps the copy safe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < HEIGHT; r++) rows[r] <= '0;
            full_lines    <= '0;
            lines_cleared <= '0;
            lines_total   <= '0;
            src           <= LAST_ROW;
            dst           <= LAST_ROW;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        for (int r = 0; r < HEIGHT; r++) rows[r] <= board_in[r*WIDTH +: WIDTH];
                end
                SCAN: begin
                    full_lines    <= row_full;
                    lines_cleared <= popcount(row_full);
                    src           <= LAST_ROW;
                    dst           <= LAST_ROW;
                end
                COMPACT: begin
                    src <= src - IDX_W'(1);
                    if (!full_lines[src]) begin
                        rows[dst] <= rows[src];
                        dst       <= dst - IDX_W'(1);
                    end
                end
                FILL: begin
                    rows[dst] <= '0;
                    dst       <= dst - IDX_W'(1);
                end
                DONE: lines_total <= sat_add(lines_total, lines_cleared);
                default: ;
            endcase
            if (clr_total) lines_total <= '0;
        end
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench for line_clear_engine: default 10x20 instance plus a
// TOTAL_W=3 instance sharing the same inputs to exercise total saturation.
module tb_line_clear_engine;

    localparam int W  = 10;
    localparam int H  = 20;
    localparam int BN = W * H;
    localparam int CW = $clog2(H + 1);

    typedef struct {
        logic [0:BN-1] board;
        logic [H-1:0]  mask;
        logic [CW-1:0] cnt;
        int            lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [0:BN-1]     board_in;
    logic              clr_total;
    logic              busy, done, full_line;
    logic [0:BN-1]     board_out;
    logic [H-1:0]      full_lines;
    logic [CW-1:0]     lines_cleared;
    logic [15:0]       lines_total;
    logic              s_busy, s_done, s_line;
    logic [0:BN-1]     s_board;
    logic [H-1:0]      s_mask;
    logic [CW-1:0]     s_cnt;
    logic [2:0]        s_total;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_total = 0;
    int   exp_sat = 0;

    always #5 clk = ~clk;

    line_clear_engine #(.WIDTH(W), .HEIGHT(H), .TOTAL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .board_in(board_in), .clr_total(clr_total),
        .busy(busy), .done(done), .board_out(board_out), .full_lines(full_lines),
        .full_line(full_line), .lines_cleared(lines_cleared), .lines_total(lines_total)
    );

    line_clear_engine #(.WIDTH(W), .HEIGHT(H), .TOTAL_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .board_in(board_in), .clr_total(clr_total),
        .busy(s_busy), .done(s_done), .board_out(s_board), .full_lines(s_mask),
        .full_line(s_line), .lines_cleared(s_cnt), .lines_total(s_total)
    );

    // Reference result: full rows vanish, surviving rows keep their order and
    // settle at the bottom, the top is zero-filled.
    function automatic exp_t model(input logic [0:BN-1] b);
        exp_t e;
        int d, n;
        e.board = '0;
        e.mask  = '0;
        d = H - 1;
        n = 0;
        for (int r = 0; r < H; r++) begin
            e.mask[r] = &b[r*W +: W];
            if (e.mask[r]) n++;
        end
        for (int s = H - 1; s >= 0; s--) begin
            if (!e.mask[s]) begin
                e.board[d*W +: W] = b[s*W +: W];
                d--;
            end
        end
        e.cnt = CW'(n);
        e.lat = (n == 0) ? 1 : H + 1 + n;
        return e;
    endfunction

    task automatic run_clear(input logic [0:BN-1] b, input exp_t e, input bit poke, input bit clr);
        exp_t got;
        bit   seen;
        seen = 0;
        sb.push_back(e);
        @(negedge clk);
        board_in = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        board_in = {BN{1'b1}};
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start got=%b want=1", busy); end
        for (int k = 1; k <= 3 * H + 10; k++) begin
            @(posedge clk);
            #1;
            if (poke && k == 3) start = 1'b1;
            if (poke && k == 4) start = 1'b0;
            if (k == 1) begin
                n_cmp++;
                if (full_lines !== e.mask) begin n_bad++; $display("FAIL mask_edge1 got=%h want=%h", full_lines, e.mask); end
                n_cmp++;
                if (lines_cleared !== e.cnt) begin n_bad++; $display("FAIL cnt_edge1 got=%0d want=%0d", lines_cleared, e.cnt); end
            end
            if (done === 1'b1) begin
                seen = 1;
                got = sb.pop_front();
                n_cmp++;
                if (k != got.lat) begin n_bad++; $display("FAIL latency got=%0d want=%0d", k, got.lat); end
                n_cmp++;
                if (board_out !== got.board) begin n_bad++; $display("FAIL board got=%h want=%h", board_out, got.board); end
                n_cmp++;
                if (full_lines !== got.mask) begin n_bad++; $display("FAIL mask got=%h want=%h", full_lines, got.mask); end
                n_cmp++;
                if (full_line !== (|got.mask)) begin n_bad++; $display("FAIL full_line got=%b want=%b", full_line, |got.mask); end
                n_cmp++;
                if (lines_cleared !== got.cnt) begin n_bad++; $display("FAIL cnt got=%0d want=%0d", lines_cleared, got.cnt); end
                n_cmp++;
                if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_done got=%b want=1", busy); end
                n_cmp++;
                if (lines_total !== 16'(exp_total)) begin n_bad++; $display("FAIL total_pre got=%0d want=%0d", lines_total, exp_total); end
                if (clr) clr_total = 1'b1;
                break;
            end
            n_cmp++;
            if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_mid k=%0d got=%b want=1", k, busy); end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout got=none want=done");
            sb.delete();
        end
        @(posedge clk);
        #1;
        clr_total = 1'b0;
        exp_total = clr ? 0 : exp_total + int'(e.cnt);
        exp_sat   = clr ? 0 : ((exp_sat + int'(e.cnt) > 7) ? 7 : exp_sat + int'(e.cnt));
        n_cmp++;
        if (lines_total !== 16'(exp_total)) begin n_bad++; $display("FAIL total got=%0d want=%0d", lines_total, exp_total); end
        n_cmp++;
        if (s_total !== 3'(exp_sat)) begin n_bad++; $display("FAIL sat_total got=%0d want=%0d", s_total, exp_sat); end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL idle_after got=%b%b want=00", busy, done); end
    endtask

    function automatic logic [0:BN-1] two_line_board();
        logic [0:BN-1] b;
        b = '0;
        b[19*W +: W] = '1;
        b[17*W +: W] = '1;
        b[18*W +: W] = 10'b1000000001;
        b[16*W +: W] = 10'b0000000001;
        return b;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; clr_total = 1'b0; board_in = '0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_ctl got=%b%b want=00", busy, done); end
        n_cmp++;
        if (board_out !== '0 || full_lines !== '0 || lines_cleared !== '0 || lines_total !== '0)
            begin n_bad++; $display("FAIL reset_out got=%h/%h/%0d/%0d want=0", board_out, full_lines, lines_cleared, lines_total); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_empty();
        run_clear('0, model('0), 0, 0);
    endtask

    task automatic test_two_lines();
        exp_t e;
        e.board = '0;
        e.board[19*W +: W] = 10'b1000000001;
        e.board[18*W +: W] = 10'b0000000001;
        e.mask = 20'hA0000;
        e.cnt = 5'd2;
        e.lat = 23;
        run_clear(two_line_board(), e, 0, 0);
    endtask

    task automatic test_all_full();
        exp_t e;
        e.board = '0;
        e.mask = '1;
        e.cnt = 5'd20;
        e.lat = 41;
        run_clear({BN{1'b1}}, e, 0, 0);
    endtask

    task automatic test_random_rows();
        logic [0:BN-1] b;
        for (int t = 0; t < 2; t++) begin
            for (int r = 0; r < H; r++)
                b[r*W +: W] = ($urandom_range(0, 2) == 0) ? 10'h3FF : (10'($urandom) & 10'h3FE);
            run_clear(b, model(b), 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:BN-1] b;
        @(negedge clk);
        clr_total = 1'b1;
        @(posedge clk);
        #1;
        clr_total = 1'b0;
        exp_total = 0;
        exp_sat = 0;
        n_cmp++;
        if (lines_total !== '0 || s_total !== '0) begin n_bad++; $display("FAIL clr_idle got=%0d/%0d want=0", lines_total, s_total); end
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < H; r++) b[r*W +: W] = 10'($urandom) & 10'h3FE;
            b[i*W +: W] = '1;
            b[(5+i)*W +: W] = '1;
            b[(10+2*i)*W +: W] = '1;
            b[(19-i)*W +: W] = '1;
            run_clear(b, model(b), 1, 0);
        end
        n_cmp++;
        if (lines_total !== 16'd12 || s_total !== 3'd7) begin n_bad++; $display("FAIL b2b_total got=%0d/%0d want=12/7", lines_total, s_total); end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        board_in = two_line_board();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || board_out !== '0 || full_lines !== '0 || lines_cleared !== '0)
            begin n_bad++; $display("FAIL abort_out got=%b%b/%h/%h want=0", busy, done, board_out, full_lines); end
        n_cmp++;
        if (lines_total !== '0 || s_total !== '0) begin n_bad++; $display("FAIL abort_total got=%0d/%0d want=0", lines_total, s_total); end
        repeat (3) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got=%b want=0", done); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_total = 0;
        exp_sat = 0;
    endtask

    task automatic test_clr_collide();
        run_clear(two_line_board(), model(two_line_board()), 0, 0);
        run_clear(two_line_board(), model(two_line_board()), 0, 1);
    endtask

    initial begin
        test_reset();
        test_empty();
        test_two_lines();
        test_all_full();
        test_random_rows();
        test_back_to_back();
        test_reset_abort();
        test_clr_collide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/line_clear_engine.md
# line_clear_engine

Parametrised line-clear engine for the Tetris board: captures a WIDTH×HEIGHT occupancy snapshot on `start` and flags every full row. It then compacts the board in place, one row per cycle, removing full rows, shifting the rows above down and zero-filling the top. It returns the new board, a per-row full mask, the number of rows cleared and a saturating running total. It sits between the lock-piece logic and board memory write-back, and supersedes the single-cycle full-row detector.

## Interface
- `WIDTH`, 10, columns per row (≥1)
- `HEIGHT`, 20, rows (≥2)
- `TOTAL_W`, 16, width of running cleared-line total
- `CNT_W` (localparam) = clog2(HEIGHT+1)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  capture `board_in`, begin clear; honoured only in IDLE
- `board_in`  in  WIDTH*HEIGHT  board, row r at bits [r*WIDTH +: WIDTH] in big-endian [0:N-1] order, row 0 = top, 1 = occupied
- `clr_total`  in  1  synchronous clear of `lines_total`
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse, result valid
- `board_out`  out  WIDTH*HEIGHT  compacted board, same layout
- `full_lines`  out  HEIGHT  registered full-row mask of captured board, bit r = row r
- `full_line`  out  1  OR of `full_lines`
- `lines_cleared`  out  CNT_W  popcount of `full_lines`
- `lines_total`  out  TOTAL_W  saturating accumulator of `lines_cleared`

## Operation
- States: IDLE, SCAN, COMPACT, FILL, DONE.
- IDLE: on `start`, load `board_in` into work buffer (`board_out` is this buffer), go to SCAN.
- SCAN: register `full_lines` (AND across each row of the buffer) and `lines_cleared` = popcount. Set src = dst = HEIGHT-1. If mask is zero, go to DONE; else go to COMPACT.
- COMPACT, once per cycle, using the registered mask (never recomputed):
  - If `full_lines[src]`, decrement src only.
  - Otherwise copy row src to row dst and decrement both.
  - After processing src = 0, go to FILL.
- FILL: write zeros to row dst and decrement dst, one row per cycle, until rows 0..lines_cleared-1 are zeroed; then go to DONE.
- In-place copy is safe because dst ≥ src always holds.
- DONE: `done`=1 for one cycle; add `lines_cleared` to `lines_total`, saturating at 2^TOTAL_W-1; return to IDLE.
- `board_out`, `full_lines`, `full_line` and `lines_cleared` hold until the next accepted `start`.
- `start` while busy is ignored and not queued.
- `clr_total` zeroes `lines_total` at the next edge. If it coincides with the DONE accumulate, the clear wins and the total ends at 0.
- Every row full (cleared = HEIGHT): COMPACT copies nothing and FILL zeroes all HEIGHT rows.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs and buffer 0, src/dst = HEIGHT-1.
- Reset asserted mid-operation aborts immediately; no `done`; total returns to 0.
- Let edge 0 be the edge sampling `start` and N = `lines_cleared`.
  - N = 0: `done` high in the cycle after edge 1, `board_out` = `board_in`.
  - N > 0: `done` high in the cycle after edge HEIGHT+1+N.
- `full_lines`/`lines_cleared` valid from the cycle after edge 1.
- `busy` high from the cycle after edge 0 through the `done` cycle inclusive. A new `start` is accepted on the edge that ends `done`'s cycle? No: it is accepted on the first edge where state = IDLE, i.e. the edge after the `done` cycle.
- `lines_total` updates on the edge ending the `done` cycle.

## Test plan
- Empty board, start -> `done` in the cycle after edge 1; `full_lines`=0, `lines_cleared`=0, `board_out`=0, `lines_total` unchanged.
- Default 10×20, rows 19 and 17 full, row 18 = 10'b1000000001, row 16 = 10'b0000000001, rest empty, start -> `full_lines` bits 17 and 19 set, `lines_cleared`=2, `done` after edge 23; `board_out` row 19 = 10'b1000000001, row 18 = 10'b0000000001, rows 0..17 = 0.
- All 200 bits set -> `lines_cleared`=20, `done` after edge 41, `board_out`=0.
- Three back-to-back clears of 4 lines each, with `start` pulsed during busy -> extra starts ignored, `lines_total`=12. With TOTAL_W=3, the third clear saturates `lines_total` at 7.
- Reset at edge 10 of a 2-line clear -> no `done`, all outputs 0, next start is processed normally; `clr_total` coinciding with the DONE accumulate -> `lines_total`=0.
